// File: rtl/irq_front.sv
// irq_front: interrupt front-end for the pipelined CPU.
// Synchronises, debounces and prioritises push-button requests; tracks nesting.
module irq_front #(
    parameter int N_IRQ     = 3,
    parameter int CODE_W    = 2,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic              clk,
    input  logic              in_RST,
    input  logic [N_IRQ-1:0]  btn,
    input  logic [N_IRQ-1:0]  irq_mask,
    input  logic              irq_en,
    input  logic              irq_ack,
    input  logic              irq_eret,
    output logic              irq_req,
    output logic [CODE_W-1:0] irq_code,
    output logic [N_IRQ-1:0]  pending,
    output logic [N_IRQ-1:0]  in_service
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [N_IRQ-1:0]  sync_a;
    logic [N_IRQ-1:0]  sync_s;
    logic [N_IRQ-1:0]  db;
    logic [N_IRQ-1:0]  db_d;
    logic [DB_W-1:0]   cnt [N_IRQ];

    logic [N_IRQ-1:0]  rise;
    logic [CODE_W-1:0] act;
    logic              cand_ok;
    logic [CODE_W-1:0] cand_code;
    logic              take;
    logic [N_IRQ-1:0]  take_oh;
    logic [N_IRQ-1:0]  top_oh;
    logic [N_IRQ-1:0]  pop_oh;
    logic [N_IRQ-1:0]  pend_nx;
    logic [N_IRQ-1:0]  isv_nx;

    // Two-flop synchroniser per raw button line.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            sync_a <= '0;
            sync_s <= '0;
        end else begin
            sync_a <= btn;
            sync_s <= sync_a;
        end
    end

    // Debounce: level follows the synchronised input only after a full stable run.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db_d <= db;
            for (int i = 0; i < N_IRQ; i++) begin
                if (sync_s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= sync_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = db & ~db_d;

    // Priority resolution plus next-state for pending latches and nesting stack.
    always_comb begin
        act       = '0;
        cand_ok   = 1'b0;
        cand_code = '0;
        take      = irq_ack && irq_req;
        take_oh   = '0;
        top_oh    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (in_service[i]) begin
                act       = CODE_W'(i + 1);
                top_oh    = '0;
                top_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (pending[i] && irq_mask[i] && (CODE_W'(i + 1) > act)) begin
                cand_ok   = 1'b1;
                cand_code = CODE_W'(i + 1);
            end
            if (take && (irq_code == CODE_W'(i + 1))) begin
                take_oh[i] = 1'b1;
            end
        end
        pop_oh  = irq_eret ? top_oh : '0;
        // A fresh rise on the line being acked re-arms it in the same cycle.
        pend_nx = (pending & ~take_oh) | rise;
        // Pop the active handler before pushing the newly taken one.
        isv_nx  = (in_service & ~pop_oh) | take_oh;
    end

    // Registered request, code, pending and in-service state.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            pending    <= '0;
            in_service <= '0;
            irq_req    <= 1'b0;
            irq_code   <= '0;
        end else begin
            pending    <= pend_nx;
            in_service <= isv_nx;
            irq_req    <= irq_en && cand_ok;
            irq_code   <= cand_code;
        end
    end

endmodule
